// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction-fetch sequencer with one-slot IF/ID buffer, skid entry and redirect flush
// Optional misaligned-target trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_ctrl #(
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter logic [ADDR_W-1:0] TRAP_VEC = ADDR_W'(32'h00000080)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_i,
   input  logic              branch_taken_i,
   input  logic [ADDR_W-1:0] branch_pc_i,
   output logic              imem_req_o,
   output logic [ADDR_W-1:0] imem_addr_o,
   input  logic              imem_ack_i,
   input  logic [DATA_W-1:0] imem_data_i,
   output logic              inst_valid_o,
   output logic [DATA_W-1:0] inst_o,
   output logic [ADDR_W-1:0] pc_o
`ifdef FETCH_MISALIGN_TRAP_EN
   ,
   output logic              misalign_o,
   output logic [ADDR_W-1:0] misalign_addr_o
`endif
);

   typedef enum logic [1:0] {IDLE, FETCH, HOLD, FLUSH} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0] flush_tgt_q, flush_tgt_d;
   logic              req_q, req_d;
   logic              valid_q, valid_d;
   logic [DATA_W-1:0] inst_q, inst_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [DATA_W-1:0] skid_inst_q, skid_inst_d;
   logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;
   logic [ADDR_W-1:0] target;
   logic              consume;
   logic              ack;

`ifdef FETCH_MISALIGN_TRAP_EN
   logic              misalign_q, misalign_d;
   logic [ADDR_W-1:0] misalign_addr_q, misalign_addr_d;
   logic              misaligned;

   assign misaligned = |branch_pc_i[1:0];
   assign target     = misaligned ? TRAP_VEC : branch_pc_i;
`else
   assign target     = branch_pc_i & ~ADDR_W'(3);
`endif

   assign consume = valid_q && !stall_i;
   assign ack     = req_q && imem_ack_i;

   always_comb begin
      state_d     = state_q;
      fetch_pc_d  = fetch_pc_q;
      flush_tgt_d = flush_tgt_q;
      req_d       = req_q;
      valid_d     = valid_q;
      inst_d      = inst_q;
      pc_d        = pc_q;
      skid_inst_d = skid_inst_q;
      skid_pc_d   = skid_pc_q;
      if (branch_taken_i) begin
         valid_d     = 1'b0;
         skid_inst_d = '0;
         skid_pc_d   = '0;
         req_d       = 1'b1;
         // An unacked request cannot be withdrawn, so it is drained in FLUSH.
         if (req_q && !imem_ack_i) begin
            state_d     = FLUSH;
            flush_tgt_d = target;
         end else begin
            state_d    = FETCH;
            fetch_pc_d = target;
         end
      end else begin
         case (state_q)
            IDLE: begin
               state_d = FETCH;
               req_d   = 1'b1;
            end
            FETCH: begin
               if (ack) begin
                  fetch_pc_d = fetch_pc_q + ADDR_W'(4);
                  if (!valid_q || consume) begin
                     valid_d = 1'b1;
                     inst_d  = imem_data_i;
                     pc_d    = fetch_pc_q;
                  end else begin
                     skid_inst_d = imem_data_i;
                     skid_pc_d   = fetch_pc_q;
                     req_d       = 1'b0;
                     state_d     = HOLD;
                  end
               end else begin
                  if (consume) valid_d = 1'b0;
                  if (!req_q) req_d = !(valid_q && stall_i);
               end
            end
            HOLD: begin
               if (consume) begin
                  inst_d  = skid_inst_q;
                  pc_d    = skid_pc_q;
                  req_d   = 1'b1;
                  state_d = FETCH;
               end
            end
            FLUSH: begin
               if (imem_ack_i) begin
                  fetch_pc_d = flush_tgt_q;
                  req_d      = 1'b1;
                  state_d    = FETCH;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

`ifdef FETCH_MISALIGN_TRAP_EN
   always_comb begin
      misalign_d      = branch_taken_i && misaligned;
      misalign_addr_d = misalign_d ? branch_pc_i : misalign_addr_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         misalign_q      <= 1'b0;
         misalign_addr_q <= '0;
      end else begin
         misalign_q      <= misalign_d;
         misalign_addr_q <= misalign_addr_d;
      end
   end

   assign misalign_o      = misalign_q;
   assign misalign_addr_o = misalign_addr_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         fetch_pc_q  <= RESET_PC;
         flush_tgt_q <= '0;
         req_q       <= 1'b0;
         valid_q     <= 1'b0;
         inst_q      <= '0;
         pc_q        <= '0;
         skid_inst_q <= '0;
         skid_pc_q   <= '0;
      end else begin
         state_q     <= state_d;
         fetch_pc_q  <= fetch_pc_d;
         flush_tgt_q <= flush_tgt_d;
         req_q       <= req_d;
         valid_q     <= valid_d;
         inst_q      <= inst_d;
         pc_q        <= pc_d;
         skid_inst_q <= skid_inst_d;
         skid_pc_q   <= skid_pc_d;
      end
   end

   assign imem_req_o   = req_q;
   assign imem_addr_o  = fetch_pc_q;
   assign inst_valid_o = valid_q;
   assign inst_o       = inst_q;
   assign pc_o         = pc_q;

endmodule
